// File: rtl/silly_if.sv
// silly_if: operand/result bundle for the silly full-adder block.
//   a, b      operands (WIDTH bits), driven by the master
//   c         carry-in into bit 0, driven by the master
//   sum, Cout combinational result, driven by the slave
//   sum_q     registered sum, driven by the slave
//   cout_q    registered carry-out, driven by the slave
//   carry_cnt saturating count of edges with Cout=1, driven by the slave
// The WIDTH and CNT_W parameters here must match those of the silly instance.
interface silly_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic [WIDTH-1:0] sum;
   logic             Cout;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic [CNT_W-1:0] carry_cnt;

   modport master (
      output a, b, c,
      input  sum, Cout, sum_q, cout_q, carry_cnt
   );

   modport slave (
      input  a, b, c,
      output sum, Cout, sum_q, cout_q, carry_cnt
   );
endinterface

// File: rtl/silly.sv
// silly: ripple-carry adder built from WIDTH full-adder cells.
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    silly_if slave port:
//            a, b, c         operands and carry-in
//            sum, Cout       combinational (a+b+c), zero latency
//            sum_q, cout_q   result registered on clk
//            carry_cnt       edges at which Cout was 1, saturating
module silly #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic    clk,
   input  logic    reset,
   silly_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_c;

   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic [CNT_W-1:0] cnt_r;

   // Carry ripples through one cell per bit; carry[i] is the carry into cell i.
   always_comb begin
      carry    = '0;
      sum_c    = '0;
      carry[0] = bus.c;
      for (int i = 0; i < WIDTH; i++) begin
         sum_c[i]   = bus.a[i] ^ bus.b[i] ^ carry[i];
         carry[i+1] = (bus.a[i] & bus.b[i])
                    | (bus.a[i] & carry[i])
                    | (bus.b[i] & carry[i]);
      end
   end

   assign bus.sum  = sum_c;
   assign bus.Cout = carry[WIDTH];

   // Reset wins over the counter increment at the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_r  <= '0;
         cout_r <= 1'b0;
         cnt_r  <= '0;
      end else begin
         sum_r  <= sum_c;
         cout_r <= carry[WIDTH];
         if (carry[WIDTH] && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign bus.sum_q     = sum_r;
   assign bus.cout_q    = cout_r;
   assign bus.carry_cnt = cnt_r;

endmodule

// File: tb/tb_silly.sv
module tb_silly;

   logic clk;
   logic reset;

   int n_cmp;
   int n_err;

   silly_if #(.WIDTH(1), .CNT_W(2)) if_a ();
   silly_if #(.WIDTH(4), .CNT_W(8)) if_b ();

   silly #(.WIDTH(1), .CNT_W(2)) u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
   silly #(.WIDTH(4), .CNT_W(8)) u_b (.clk(clk), .reset(reset), .bus(if_b.slave));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference state: what each registered output should hold.
   int ma_sq, ma_cq, ma_cnt;
   int mb_sq, mb_cq, mb_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int tot_a();
      return int'(if_a.a) + int'(if_a.b) + int'(if_a.c);
   endfunction

   function automatic int tot_b();
      return int'(if_b.a) + int'(if_b.b) + int'(if_b.c);
   endfunction

   task automatic chk_comb();
      chk("a_sum",  32'(if_a.sum),  32'(tot_a() % 2));
      chk("a_cout", 32'(if_a.Cout), 32'(tot_a() / 2));
      chk("b_sum",  32'(if_b.sum),  32'(tot_b() % 16));
      chk("b_cout", 32'(if_b.Cout), 32'(tot_b() / 16));
   endtask

   task automatic chk_regs();
      chk("a_sum_q",  32'(if_a.sum_q),     32'(ma_sq));
      chk("a_cout_q", 32'(if_a.cout_q),    32'(ma_cq));
      chk("a_cnt",    32'(if_a.carry_cnt), 32'(ma_cnt));
      chk("b_sum_q",  32'(if_b.sum_q),     32'(mb_sq));
      chk("b_cout_q", 32'(if_b.cout_q),    32'(mb_cq));
      chk("b_cnt",    32'(if_b.carry_cnt), 32'(mb_cnt));
   endtask

   // One clock edge: model the edge from the inputs present before it, then check.
   task automatic tick();
      int ta;
      int tb_v;
      logic rs;
      ta   = tot_a();
      tb_v = tot_b();
      rs   = reset;
      @(posedge clk);
      #1;
      if (rs) begin
         ma_sq = 0; ma_cq = 0; ma_cnt = 0;
         mb_sq = 0; mb_cq = 0; mb_cnt = 0;
      end else begin
         ma_sq = ta % 2;
         ma_cq = ta / 2;
         if (ma_cq == 1 && ma_cnt < 3) ma_cnt++;
         mb_sq = tb_v % 16;
         mb_cq = tb_v / 16;
         if (mb_cq == 1 && mb_cnt < 255) mb_cnt++;
      end
      chk_regs();
   endtask

   task automatic set_a(input int abc);
      logic [2:0] v;
      v = 3'(abc);
      if_a.a = v[2];
      if_a.b = v[1];
      if_a.c = v[0];
   endtask

   initial begin
      int tab [8];
      int want_cnt [5];
      logic [2:0] idx;
      n_cmp = 0;
      n_err = 0;
      tab      = '{0, 1, 1, 2, 1, 2, 2, 3};
      want_cnt = '{1, 2, 3, 3, 3};
      ma_sq = 0; ma_cq = 0; ma_cnt = 0;
      mb_sq = 0; mb_cq = 0; mb_cnt = 0;

      reset  = 1'b1;
      if_a.a = '0; if_a.b = '0; if_a.c = 1'b0;
      if_b.a = '0; if_b.b = '0; if_b.c = 1'b0;

      // Reset state.
      tick();
      tick();
      chk("rst_a_cnt", 32'(if_a.carry_cnt), 32'd0);
      reset = 1'b0;

      // WIDTH=1 exhaustive against the truth table.
      for (int i = 0; i < 8; i++) begin
         set_a(i);
         #1;
         idx = 3'(i);
         chk("tt_cout_sum", {30'd0, if_a.Cout, if_a.sum}, 32'(tab[idx]));
         chk_comb();
         #8;
         tick();
      end

      // Latency: combinational carry now, registered carry after the edge.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_a(3);
      #1;
      chk("lat_cout", 32'(if_a.Cout), 32'd1);
      chk("lat_cout_q_before", 32'(if_a.cout_q), 32'd0);
      tick();
      chk("lat_cout_q_after", 32'(if_a.cout_q), 32'd1);

      // Reset held with abc=111: registers clear, comb path keeps tracking.
      set_a(7);
      reset = 1'b1;
      tick();
      chk("rst_sum_q", 32'(if_a.sum_q), 32'd0);
      chk("rst_cout_q", 32'(if_a.cout_q), 32'd0);
      chk("rst_cnt", 32'(if_a.carry_cnt), 32'd0);
      chk("rst_sum", 32'(if_a.sum), 32'd1);
      chk("rst_cout", 32'(if_a.Cout), 32'd1);

      // Saturation with CNT_W=2.
      reset = 1'b0;
      set_a(6);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sat_cnt", 32'(if_a.carry_cnt), 32'(want_cnt[i]));
      end

      // Reset and carry at the same edge: reset wins.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("mid_cnt_pre", 32'(if_a.carry_cnt), 32'd2);
      reset = 1'b1;
      tick();
      chk("mid_cnt_rst", 32'(if_a.carry_cnt), 32'd0);
      reset = 1'b0;

      // WIDTH=4 directed.
      if_b.a = 4'hF; if_b.b = 4'h0; if_b.c = 1'b1;
      #1;
      chk("w4_f01_sum", 32'(if_b.sum), 32'h0);
      chk("w4_f01_cout", 32'(if_b.Cout), 32'd1);
      tick();
      if_b.a = 4'h5; if_b.b = 4'h3; if_b.c = 1'b0;
      #1;
      chk("w4_530_sum", 32'(if_b.sum), 32'h8);
      chk("w4_530_cout", 32'(if_b.Cout), 32'd0);
      tick();

      // Random operands with occasional resets.
      for (int i = 0; i < 300; i++) begin
         set_a(int'($urandom_range(0, 7)));
         if_b.a = 4'($urandom_range(0, 15));
         if_b.b = 4'($urandom_range(0, 15));
         if_b.c = 1'($urandom_range(0, 1));
         reset  = ($urandom_range(0, 19) == 0);
         #1;
         chk_comb();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
